hazard_controller: RTL and testbench



---
 rtl/core_ctrl_pkg.sv | 15 +
 rtl/hazard_controller_if.sv | 51 +++++
 rtl/hazard_controller_hazard_detect.sv | 32 +++
 rtl/hazard_controller.sv | 150 +++++++++++++++
 tb/tb_hazard_controller.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared control definitions for the core pipeline sequencing logic.
// Contents:
//   hc_state_e : hazard controller sequencing states
//   REG_ZERO   : architectural x0 index (never a real dependency)
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        HC_RUN,
        HC_LOAD_STALL,
        HC_MULDIV
    } hc_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline <-> hazard controller signal bundle.
// master : pipeline side (drives hazard sources, receives stage controls)
// slave  : hazard controller (consumes hazard sources, drives stage controls
//          and the stall/flush statistics counters)
interface hazard_controller_if #(
    parameter int CNT_WIDTH = 32
);
    // hazard sources
    logic                 id_use_rs1;
    logic                 id_use_rs2;
    logic [4:0]           id_rs1;
    logic [4:0]           id_rs2;
    logic                 ex_mem_read;
    logic [4:0]           ex_rd;
    logic                 ex_redirect;
    logic                 ex_md_op;
    logic                 md_done;
    logic                 dmem_req;
    logic                 dmem_ready;
    // stage controls
    logic                 pc_en;
    logic                 ifid_en;
    logic                 idex_en;
    logic                 exmem_en;
    logic                 memwb_en;
    logic                 ifid_flush;
    logic                 idex_flush;
    logic                 exmem_flush;
    logic                 memwb_flush;
    logic                 md_start;
    // statistics
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt;

    modport master (
        output id_use_rs1, id_use_rs2, id_rs1, id_rs2, ex_mem_read, ex_rd,
               ex_redirect, ex_md_op, md_done, dmem_req, dmem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               md_start, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_use_rs1, id_use_rs2, id_rs1, id_rs2, ex_mem_read, ex_rd,
               ex_redirect, ex_md_op, md_done, dmem_req, dmem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               md_start, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_controller_hazard_detect.sv
// Combinational hazard detection for the hazard controller.
// Ports:
//   i_id_use_rs1/2, i_id_rs1/2 : ID source operand usage and indices
//   i_ex_mem_read, i_ex_rd     : EX load flag and destination
//   i_dmem_req, i_dmem_ready   : MEM stage data-memory handshake
//   o_load_use                 : ID depends on a load still in EX
//   o_mem_wait                 : MEM request outstanding this cycle
module hazard_detect
    import core_ctrl_pkg::*;
(
    input  logic       i_id_use_rs1,
    input  logic       i_id_use_rs2,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_rd,
    input  logic       i_dmem_req,
    input  logic       i_dmem_ready,
    output logic       o_load_use,
    output logic       o_mem_wait
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit  = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit  = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
    // x0 writes are discarded, so a load to x0 never creates a dependency
    assign o_load_use = i_ex_mem_read && (i_ex_rd != REG_ZERO) && (w_rs1_hit || w_rs2_hit);
    assign o_mem_wait = i_dmem_req && !i_dmem_ready;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the 5-stage RV32 core.
// Decides per cycle which pipeline registers advance, hold or load a NOP,
// and keeps free-running stall/flush statistics.
// Ports:
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : hazard sources in, stage enables/flushes, md_start and
//           statistics counters out (hazard_controller_if.slave)
module hazard_controller
    import core_ctrl_pkg::*;
#(
    parameter int LOAD_BUBBLES = 1,
    parameter int CNT_WIDTH    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_controller_if.slave bus
);

    localparam logic [1:0] BUB_INIT = 2'(LOAD_BUBBLES - 1);

    hc_state_e            r_state;
    hc_state_e            w_state_nxt;
    logic [1:0]           r_bub;
    logic [1:0]           w_bub_nxt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;

    logic w_load_use;
    logic w_mem_wait;
    logic w_redirect_evt;
    logic w_md_start;
    logic w_pc_en;
    logic w_ifid_en;
    logic w_idex_en;
    logic w_exmem_en;
    logic w_memwb_en;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_exmem_flush;
    logic w_memwb_flush;

    hazard_detect u_detect (
        .i_id_use_rs1  (bus.id_use_rs1),
        .i_id_use_rs2  (bus.id_use_rs2),
        .i_id_rs1      (bus.id_rs1),
        .i_id_rs2      (bus.id_rs2),
        .i_ex_mem_read (bus.ex_mem_read),
        .i_ex_rd       (bus.ex_rd),
        .i_dmem_req    (bus.dmem_req),
        .i_dmem_ready  (bus.dmem_ready),
        .o_load_use    (w_load_use),
        .o_mem_wait    (w_mem_wait)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_bub_nxt      = r_bub;
        w_redirect_evt = 1'b0;
        w_md_start     = 1'b0;
        w_pc_en        = 1'b1;
        w_ifid_en      = 1'b1;
        w_idex_en      = 1'b1;
        w_exmem_en     = 1'b1;
        w_memwb_en     = 1'b1;
        w_ifid_flush   = 1'b0;
        w_idex_flush   = 1'b0;
        w_exmem_flush  = 1'b0;
        w_memwb_flush  = 1'b0;

        if (w_mem_wait) begin
            // Freeze everything upstream of MEM; WB gets a NOP so the
            // instruction already in MEM/WB is not retired twice.
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_idex_en     = 1'b0;
            w_exmem_en    = 1'b0;
            w_memwb_flush = 1'b1;
        end else if (r_state == HC_MULDIV || (r_state == HC_RUN && bus.ex_md_op)) begin
            // The issue cycle and the wait cycles share one decode; only
            // the issue cycle (still in RUN) pulses md_start.
            w_pc_en    = 1'b0;
            w_ifid_en  = 1'b0;
            w_idex_en  = 1'b0;
            w_md_start = (r_state == HC_RUN);
            if (bus.md_done) begin
                w_exmem_en  = 1'b1;
                w_state_nxt = HC_RUN;
            end else begin
                w_exmem_en    = 1'b0;
                w_exmem_flush = 1'b1;
                w_state_nxt   = HC_MULDIV;
            end
        end else if (r_state == HC_LOAD_STALL) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
            w_bub_nxt    = r_bub - 2'd1;
            if (r_bub == 2'd1) begin
                w_state_nxt = HC_RUN;
            end
        end else if (bus.ex_redirect) begin
            // Redirect squashes the ID instruction, so any load-use on it is moot.
            w_ifid_flush   = 1'b1;
            w_idex_flush   = 1'b1;
            w_redirect_evt = 1'b1;
        end else if (w_load_use) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
            if (LOAD_BUBBLES > 1) begin
                w_state_nxt = HC_LOAD_STALL;
                w_bub_nxt   = BUB_INIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= HC_RUN;
            r_bub       <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bub   <= w_bub_nxt;
            if (!w_pc_en) begin
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            end
            if (w_redirect_evt) begin
                r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.pc_en       = w_pc_en;
    assign bus.ifid_en     = w_ifid_en;
    assign bus.idex_en     = w_idex_en;
    assign bus.exmem_en    = w_exmem_en;
    assign bus.memwb_en    = w_memwb_en;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.idex_flush  = w_idex_flush;
    assign bus.exmem_flush = w_exmem_flush;
    assign bus.memwb_flush = w_memwb_flush;
    // Gated by rst_n so the start pulse drops as soon as reset asserts.
    assign bus.md_start    = w_md_start && rst_n;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Testbench for hazard_controller: two instances (LOAD_BUBBLES=1 with 32-bit
// counters, LOAD_BUBBLES=3 with 4-bit counters) share one stimulus stream.
// Directed vector table, hand-written multi-cycle sequences and random
// stimulus, all checked against a behavioural reference model.
module tb_hazard_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // shared stimulus
    logic       s_use1, s_use2;
    logic [4:0] s_rs1, s_rs2, s_exrd;
    logic       s_mr, s_redir, s_mdop, s_mddone, s_req, s_rdy;

    hazard_controller_if #(.CNT_WIDTH(32)) ifa ();
    hazard_controller_if #(.CNT_WIDTH(4))  ifb ();

    hazard_controller #(.LOAD_BUBBLES(1), .CNT_WIDTH(32)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    hazard_controller #(.LOAD_BUBBLES(3), .CNT_WIDTH(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    assign ifa.id_use_rs1  = s_use1;
    assign ifa.id_use_rs2  = s_use2;
    assign ifa.id_rs1      = s_rs1;
    assign ifa.id_rs2      = s_rs2;
    assign ifa.ex_mem_read = s_mr;
    assign ifa.ex_rd       = s_exrd;
    assign ifa.ex_redirect = s_redir;
    assign ifa.ex_md_op    = s_mdop;
    assign ifa.md_done     = s_mddone;
    assign ifa.dmem_req    = s_req;
    assign ifa.dmem_ready  = s_rdy;

    assign ifb.id_use_rs1  = s_use1;
    assign ifb.id_use_rs2  = s_use2;
    assign ifb.id_rs1      = s_rs1;
    assign ifb.id_rs2      = s_rs2;
    assign ifb.ex_mem_read = s_mr;
    assign ifb.ex_rd       = s_exrd;
    assign ifb.ex_redirect = s_redir;
    assign ifb.ex_md_op    = s_mdop;
    assign ifb.md_done     = s_mddone;
    assign ifb.dmem_req    = s_req;
    assign ifb.dmem_ready  = s_rdy;

    // {pc,ifid,idex,exmem,memwb, ifid_f,idex_f,exmem_f,memwb_f, md_start}
    logic [9:0] oa, ob;
    assign oa = {ifa.pc_en, ifa.ifid_en, ifa.idex_en, ifa.exmem_en, ifa.memwb_en,
                 ifa.ifid_flush, ifa.idex_flush, ifa.exmem_flush, ifa.memwb_flush, ifa.md_start};
    assign ob = {ifb.pc_en, ifb.ifid_en, ifb.idex_en, ifb.exmem_en, ifb.memwb_en,
                 ifb.ifid_flush, ifb.idex_flush, ifb.exmem_flush, ifb.memwb_flush, ifb.md_start};

    localparam logic [9:0] O_RUN   = 10'b11111_0000_0;
    localparam logic [9:0] O_LOAD  = 10'b00111_0100_0;
    localparam logic [9:0] O_REDIR = 10'b11111_1100_0;
    localparam logic [9:0] O_MWAIT = 10'b00001_0001_0;

    int unsigned nvec  = 0;
    int unsigned nfail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // bub  : stall cycles still owed after the initial load-use cycle
    // busy : a mul/div has been issued and its result is not yet taken
    typedef struct {
        int          bub;
        bit          busy;
        longint unsigned stall;
        longint unsigned flush;
    } mdl_t;

    mdl_t ma, mb;

    function automatic bit m_load_use();
        return s_mr && (s_exrd != 5'd0) &&
               ((s_use1 && s_rs1 == s_exrd) || (s_use2 && s_rs2 == s_exrd));
    endfunction

    function automatic logic [9:0] m_out(input mdl_t m);
        bit pc = 1, ifid = 1, idex = 1, exm = 1, mwb = 1;
        bit f1 = 0, f2 = 0, f3 = 0, f4 = 0, ms = 0;
        if (s_req && !s_rdy) begin
            pc = 0; ifid = 0; idex = 0; exm = 0; f4 = 1;
        end else if (m.busy || (m.bub == 0 && s_mdop)) begin
            pc = 0; ifid = 0; idex = 0;
            exm = s_mddone; f3 = !s_mddone; ms = !m.busy;
        end else if (m.bub > 0) begin
            pc = 0; ifid = 0; f2 = 1;
        end else if (s_redir) begin
            f1 = 1; f2 = 1;
        end else if (m_load_use()) begin
            pc = 0; ifid = 0; f2 = 1;
        end
        return {pc, ifid, idex, exm, mwb, f1, f2, f3, f4, ms};
    endfunction

    function automatic mdl_t m_next(input mdl_t m, input int lb);
        mdl_t r = m;
        logic [9:0] o = m_out(m);
        if (!o[9]) r.stall++;
        if (s_req && !s_rdy) begin
            // frozen: nothing advances
        end else if (m.busy || (m.bub == 0 && s_mdop)) begin
            r.busy = !s_mddone;
        end else if (m.bub > 0) begin
            r.bub = m.bub - 1;
        end else if (s_redir) begin
            r.flush++;
        end else if (m_load_use()) begin
            r.bub = lb - 1;
        end
        return r;
    endfunction

    // ---------------- sequencing helpers ----------------
    task automatic idle();
        s_use1 = 0; s_use2 = 0; s_rs1 = 0; s_rs2 = 0; s_exrd = 0;
        s_mr = 0; s_redir = 0; s_mdop = 0; s_mddone = 0; s_req = 0; s_rdy = 0;
    endtask

    // wait to the sampling point and compare both DUTs to the model
    task automatic at_neg();
        @(negedge clk);
        chk("a_ctrl", 64'(oa), 64'(m_out(ma)));
        chk("b_ctrl", 64'(ob), 64'(m_out(mb)));
        chk("a_stall_cnt", 64'(ifa.stall_cnt), ma.stall & 64'hffff_ffff);
        chk("a_flush_cnt", 64'(ifa.flush_cnt), ma.flush & 64'hffff_ffff);
        chk("b_stall_cnt", 64'(ifb.stall_cnt), mb.stall & 64'hf);
        chk("b_flush_cnt", 64'(ifb.flush_cnt), mb.flush & 64'hf);
    endtask

    task automatic to_next();
        ma = m_next(ma, 1);
        mb = m_next(mb, 3);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        ma = '{0, 0, 0, 0};
        mb = '{0, 0, 0, 0};
        #1;
        chk("rst_a_ctrl", 64'(oa), 64'(O_RUN));
        chk("rst_b_ctrl", 64'(ob), 64'(O_RUN));
        chk("rst_a_stall", 64'(ifa.stall_cnt), 64'd0);
        chk("rst_a_flush", 64'(ifa.flush_cnt), 64'd0);
        chk("rst_b_stall", 64'(ifb.stall_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table (instance A, stays in RUN) ----------------
    typedef struct {
        logic       use1, use2;
        logic [4:0] rs1, rs2, exrd;
        logic       mr, redir, mdop, mddone, req, rdy;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //          u1 u2 rs1 rs2 exrd mr rd mo md rq ry  expected
        tbl[0]  = '{0, 0, 0,  0,  0,   0, 0, 0, 0, 0, 0,  O_RUN};
        tbl[1]  = '{1, 0, 5,  0,  5,   1, 0, 0, 0, 0, 0,  O_LOAD};
        tbl[2]  = '{1, 0, 0,  0,  0,   1, 0, 0, 0, 0, 0,  O_RUN};
        tbl[3]  = '{0, 1, 3,  7,  7,   1, 0, 0, 0, 0, 0,  O_LOAD};
        tbl[4]  = '{1, 0, 3,  7,  7,   1, 0, 0, 0, 0, 0,  O_RUN};
        tbl[5]  = '{1, 0, 5,  0,  5,   0, 0, 0, 0, 0, 0,  O_RUN};
        tbl[6]  = '{1, 0, 5,  0,  5,   1, 1, 0, 0, 0, 0,  O_REDIR};
        tbl[7]  = '{0, 0, 0,  0,  0,   0, 0, 0, 0, 1, 0,  O_MWAIT};
        tbl[8]  = '{1, 0, 5,  0,  5,   1, 1, 0, 0, 1, 0,  O_MWAIT};
        tbl[9]  = '{0, 0, 0,  0,  0,   0, 0, 0, 0, 1, 1,  O_RUN};
        tbl[10] = '{0, 0, 0,  0,  0,   0, 0, 1, 1, 0, 0,  10'b00011_0000_1};
        tbl[11] = '{0, 0, 0,  0,  0,   0, 1, 0, 0, 0, 0,  O_REDIR};

        idle();
        do_reset();

        for (int i = 0; i < 12; i++) begin
            s_use1 = tbl[i].use1; s_use2 = tbl[i].use2;
            s_rs1 = tbl[i].rs1; s_rs2 = tbl[i].rs2; s_exrd = tbl[i].exrd;
            s_mr = tbl[i].mr; s_redir = tbl[i].redir; s_mdop = tbl[i].mdop;
            s_mddone = tbl[i].mddone; s_req = tbl[i].req; s_rdy = tbl[i].rdy;
            at_neg();
            chk($sformatf("tbl[%0d]", i), 64'(oa), 64'(tbl[i].exp));
            to_next();
        end
        idle();
        at_neg();
        // rows 6 and 11 are counted redirects; row 8 is frozen by mem_wait
        chk("tbl_flush_cnt", 64'(ifa.flush_cnt), 64'd2);
        to_next();

        // ---- mul/div with result on the 5th cycle ----
        do_reset();
        s_mdop = 1;
        for (int c = 0; c < 5; c++) begin
            s_mddone = (c == 4);
            at_neg();
            chk("md_start", 64'(ifa.md_start), 64'(c == 0));
            chk("md_exmem_flush", 64'(ifa.exmem_flush), 64'(c != 4));
            chk("md_exmem_en", 64'(ifa.exmem_en), 64'(c == 4));
            chk("md_pc_en", 64'(ifa.pc_en), 64'd0);
            to_next();
        end
        idle();
        at_neg();
        chk("md_after", 64'(oa), 64'(O_RUN));
        chk("md_stall_cnt", 64'(ifa.stall_cnt), 64'd5);
        to_next();

        // ---- memory wait while mul/div result is already valid ----
        do_reset();
        s_mdop = 1;
        at_neg();
        to_next();
        s_mddone = 1; s_req = 1; s_rdy = 0;
        for (int c = 0; c < 3; c++) begin
            at_neg();
            chk("mdw_frozen", 64'(oa), 64'(O_MWAIT));
            to_next();
        end
        s_rdy = 1;
        at_neg();
        chk("mdw_complete", 64'(oa), 64'(10'b00011_0000_0));
        to_next();
        idle();
        at_neg();
        chk("mdw_after", 64'(oa), 64'(O_RUN));
        to_next();

        // ---- LOAD_BUBBLES=3 with a 2-cycle mem_wait mid-stall (instance B) ----
        do_reset();
        s_use1 = 1; s_rs1 = 5; s_exrd = 5; s_mr = 1;
        at_neg();
        chk("lb3_c0", 64'(ob), 64'(O_LOAD));
        to_next();
        s_mr = 0; s_req = 1; s_rdy = 0;
        for (int c = 0; c < 2; c++) begin
            at_neg();
            chk("lb3_wait", 64'(ob), 64'(O_MWAIT));
            to_next();
        end
        s_req = 0;
        for (int c = 0; c < 2; c++) begin
            at_neg();
            chk("lb3_stall", 64'(ob), 64'(O_LOAD));
            to_next();
        end
        idle();
        at_neg();
        chk("lb3_done", 64'(ob), 64'(O_RUN));
        chk("lb3_stall_cnt", 64'(ifb.stall_cnt), 64'd5);
        to_next();

        // ---- asynchronous reset in the middle of a mul/div ----
        do_reset();
        s_mdop = 1;
        at_neg();
        to_next();
        at_neg();
        chk("rmd_busy_pc", 64'(ifa.pc_en), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmd_md_start", 64'(ifa.md_start), 64'd0);
        chk("rmd_stall_cnt", 64'(ifa.stall_cnt), 64'd0);
        chk("rmd_flush_cnt", 64'(ifa.flush_cnt), 64'd0);
        do_reset();
        at_neg();
        chk("rmd_after", 64'(oa), 64'(O_RUN));
        to_next();

        // ---- random stimulus against the model ----
        do_reset();
        for (int n = 0; n < 600; n++) begin
            s_use1   = ($urandom % 4) != 0;
            s_use2   = ($urandom % 2) != 0;
            s_rs1    = 5'($urandom_range(0, 3));
            s_rs2    = 5'($urandom_range(0, 3));
            s_exrd   = 5'($urandom_range(0, 3));
            s_mr     = ($urandom % 10) < 4;
            s_redir  = ($urandom % 10) < 2;
            s_mdop   = ($urandom % 10) < 2;
            s_mddone = ($urandom % 10) < 3;
            s_req    = ($urandom % 10) < 4;
            s_rdy    = ($urandom % 10) < 6;
            at_neg();
            to_next();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
